// File: rtl/iq_mixer_integrator.sv
// Mixes a signed sample stream with ternary cos/sin references and integrates-and-dumps
// each DUMP_LEN-sample window into one I/Q pair. Define IQ_MIX_SAT_EN for saturating adds.
module iq_mixer_integrator #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 16,
  parameter int DUMP_LEN = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_vld,
  output logic                     sample_rdy,
  input  logic [1:0]               cos_in,
  input  logic [1:0]               sin_in,
  output logic signed [ACC_W-1:0]  i_out,
  output logic signed [ACC_W-1:0]  q_out,
  output logic                     iq_vld,
  input  logic                     iq_rdy
);

  localparam int CNT_W = (DUMP_LEN > 2) ? $clog2(DUMP_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DUMP_LEN - 1);

`ifdef IQ_MIX_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] i_acc_q, i_acc_d;
  logic signed [ACC_W-1:0] q_acc_q, q_acc_d;
  logic signed [ACC_W-1:0] i_out_q, i_out_d;
  logic signed [ACC_W-1:0] q_out_q, q_out_d;
  logic                    iq_vld_q, iq_vld_d;

  logic                    last_win;
  logic                    accept;
  logic signed [ACC_W-1:0] p_i;
  logic signed [ACC_W-1:0] p_q;
  logic signed [ACC_W-1:0] sum_i;
  logic signed [ACC_W-1:0] sum_q;

  // Code 01 is +1, 11 is -1; 00 and the illegal 10 both contribute nothing.
  function automatic logic signed [ACC_W-1:0] mix(
    input logic signed [DATA_W-1:0] s,
    input logic [1:0]               code
  );
    logic signed [ACC_W-1:0] ext;
    ext = {{(ACC_W-DATA_W){s[DATA_W-1]}}, s};
    case (code)
      2'b01:   mix = ext;
      2'b11:   mix = -ext;
      default: mix = '0;
    endcase
  endfunction

  // Overflow is only possible when both operands share a sign the result lost.
  function automatic logic signed [ACC_W-1:0] acc_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic signed [ACC_W-1:0] s;
    s = a + b;
`ifdef IQ_MIX_SAT_EN
    if ((a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1])) begin
      s = a[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end
`endif
    acc_add = s;
  endfunction

  assign last_win   = (cnt_q == LAST_CNT);
  assign sample_rdy = !(last_win && iq_vld_q && !iq_rdy);
  assign accept     = sample_vld && sample_rdy;

  assign p_i   = mix(sample_in, cos_in);
  assign p_q   = mix(sample_in, sin_in);
  assign sum_i = acc_add(i_acc_q, p_i);
  assign sum_q = acc_add(q_acc_q, p_q);

  // A dump in the same cycle as an output handshake reloads the output and keeps iq_vld high.
  always_comb begin
    cnt_d    = cnt_q;
    i_acc_d  = i_acc_q;
    q_acc_d  = q_acc_q;
    i_out_d  = i_out_q;
    q_out_d  = q_out_q;
    iq_vld_d = iq_vld_q;

    if (iq_vld_q && iq_rdy) begin
      iq_vld_d = 1'b0;
    end

    if (accept) begin
      if (!last_win) begin
        i_acc_d = sum_i;
        q_acc_d = sum_q;
        cnt_d   = cnt_q + CNT_W'(1);
      end else begin
        i_out_d  = sum_i;
        q_out_d  = sum_q;
        iq_vld_d = 1'b1;
        i_acc_d  = '0;
        q_acc_d  = '0;
        cnt_d    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q    <= '0;
      i_acc_q  <= '0;
      q_acc_q  <= '0;
      i_out_q  <= '0;
      q_out_q  <= '0;
      iq_vld_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      i_acc_q  <= i_acc_d;
      q_acc_q  <= q_acc_d;
      i_out_q  <= i_out_d;
      q_out_q  <= q_out_d;
      iq_vld_q <= iq_vld_d;
    end
  end

  assign i_out  = i_out_q;
  assign q_out  = q_out_q;
  assign iq_vld = iq_vld_q;

endmodule
